// File: rtl/booth_radix4_mult.sv
`default_nettype none
// ============================================================================
//  Module      : booth_radix4_mult
//  Description : Sequential radix-4 (modified) Booth multiplier. Retires two
//                multiplier bits per cycle, with a per-operation signed or
//                unsigned mode and a start/busy/done handshake that supports
//                back-to-back operations.
//  Revision    : 1.0  initial release
// ============================================================================
module booth_radix4_mult #(
  parameter int INPUT_WIDTH  = 6,
  parameter int OUTPUT_WIDTH = 2 * INPUT_WIDTH,
  parameter int COUNTER_SIZE = 4
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    start_in,
  input  logic                    signed_in,
  input  logic [INPUT_WIDTH-1:0]  multiplicand_in,
  input  logic [INPUT_WIDTH-1:0]  multiplier_in,
  output logic                    busy_out,
  output logic                    done_out,
  output logic [OUTPUT_WIDTH-1:0] product_out,
  output logic [COUNTER_SIZE-1:0] counter_out
);

  // Extended operand width: INPUT_WIDTH plus two guard bits, rounded up to
  // even so that it splits into whole radix-4 digits.
  localparam int c_ew     = ((INPUT_WIDTH + 2 + 1) / 2) * 2;
  localparam int c_ext    = c_ew - INPUT_WIDTH;
  localparam int c_iters  = c_ew / 2;
  // Accumulator carries two extra bits so that +/-2M never overflows.
  localparam int c_aw     = c_ew + 2;
  localparam int c_fw     = c_aw + c_ew;
  localparam logic [COUNTER_SIZE-1:0] c_last = COUNTER_SIZE'(c_iters - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                  state_q,   state_d;
  logic [c_ew-1:0]         mcand_q,   mcand_d;
  logic [c_aw-1:0]         acc_q,     acc_d;
  logic [c_ew-1:0]         mplier_q,  mplier_d;
  logic                    qm1_q,     qm1_d;
  logic [COUNTER_SIZE-1:0] counter_q, counter_d;
  logic [OUTPUT_WIDTH-1:0] product_q, product_d;

  logic [c_ew-1:0] ext_mcand;
  logic [c_ew-1:0] ext_mplier;
  logic [c_aw-1:0] m_x;
  logic [c_aw-1:0] addend;
  logic [c_aw-1:0] acc_sum;
  logic [c_fw-1:0] full_sum;
  logic [c_fw-1:0] shifted;
  logic [2:0]      triplet;

  // Operand extension: sign- or zero-fill depending on the requested mode.
  always_comb begin
    ext_mcand  = {{c_ext{signed_in & multiplicand_in[INPUT_WIDTH-1]}}, multiplicand_in};
    ext_mplier = {{c_ext{signed_in & multiplier_in[INPUT_WIDTH-1]}}, multiplier_in};
  end

  // One Booth step: pick 0/+-M/+-2M from the current digit, add, shift by 2.
  always_comb begin
    m_x     = {{2{mcand_q[c_ew-1]}}, mcand_q};
    triplet = {mplier_q[1], mplier_q[0], qm1_q};
    addend  = '0;
    case (triplet)
      3'b001, 3'b010: addend = m_x;
      3'b011:         addend = m_x << 1;
      3'b100:         addend = ~(m_x << 1) + c_aw'(1);
      3'b101, 3'b110: addend = ~m_x + c_aw'(1);
      default:        addend = '0;
    endcase
    acc_sum  = acc_q + addend;
    full_sum = {acc_sum, mplier_q};
    shifted  = {{2{acc_sum[c_aw-1]}}, full_sum[c_fw-1:2]};
  end

  // Next-state and datapath update for the IDLE/RUN/DONE sequencer.
  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    acc_d     = acc_q;
    mplier_d  = mplier_q;
    qm1_d     = qm1_q;
    counter_d = counter_q;
    product_d = product_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_in) begin
          state_d   = S_RUN;
          mcand_d   = ext_mcand;
          acc_d     = '0;
          mplier_d  = ext_mplier;
          qm1_d     = 1'b0;
          counter_d = '0;
        end else begin
          state_d   = S_IDLE;
          counter_d = '0;
        end
      end
      S_RUN: begin
        acc_d     = shifted[c_fw-1:c_ew];
        mplier_d  = shifted[c_ew-1:0];
        qm1_d     = mplier_q[1];
        counter_d = counter_q + COUNTER_SIZE'(1);
        if (counter_q == c_last) begin
          state_d   = S_DONE;
          product_d = shifted[OUTPUT_WIDTH-1:0];
        end
      end
      default: begin
        state_d   = S_IDLE;
        counter_d = '0;
      end
    endcase
  end

  // State and datapath registers; reset discards any operation in flight.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q   <= S_IDLE;
      mcand_q   <= '0;
      acc_q     <= '0;
      mplier_q  <= '0;
      qm1_q     <= 1'b0;
      counter_q <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      acc_q     <= acc_d;
      mplier_q  <= mplier_d;
      qm1_q     <= qm1_d;
      counter_q <= counter_d;
      product_q <= product_d;
    end
  end

  // Status outputs decode directly from the registered state.
  always_comb begin
    busy_out    = (state_q == S_RUN);
    done_out    = (state_q == S_DONE);
    product_out = product_q;
    counter_out = counter_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_booth_radix4_mult.sv
`default_nettype none
// ============================================================================
//  Module      : tb_booth_radix4_mult
//  Description : Directed self-checking bench for booth_radix4_mult.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_booth_radix4_mult;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        start_in;
  logic        signed_in;
  logic [5:0]  multiplicand_in;
  logic [5:0]  multiplier_in;
  logic        busy_out;
  logic        done_out;
  logic [11:0] product_out;
  logic [3:0]  counter_out;

  int n_checks = 0;
  int n_errors = 0;

  booth_radix4_mult #(
    .INPUT_WIDTH  (6),
    .OUTPUT_WIDTH (12),
    .COUNTER_SIZE (4)
  ) u_dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .start_in        (start_in),
    .signed_in       (signed_in),
    .multiplicand_in (multiplicand_in),
    .multiplier_in   (multiplier_in),
    .busy_out        (busy_out),
    .done_out        (done_out),
    .product_out     (product_out),
    .counter_out     (counter_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check_value(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // Wait (bounded) for done_out; returns the number of edges waited and busy cycles seen.
  task automatic wait_done(output int cyc, output int busy_cnt);
    cyc = 0;
    busy_cnt = 0;
    while (!done_out && cyc < 20) begin
      if (busy_out) busy_cnt++;
      tick();
      cyc++;
    end
  endtask

  task automatic wait_counter(input logic [3:0] value, input string tag);
    int cyc;
    cyc = 0;
    while (counter_out != value && cyc < 20) begin
      tick();
      cyc++;
    end
    check_value(tag, 32'(counter_out), 32'(value));
  endtask

  // Full single operation: issue start, then check latency, busy width and product.
  task automatic do_mult(input logic s, input logic [5:0] a, input logic [5:0] b,
                         input logic [11:0] expected, input string tag);
    int cyc;
    int busy_cnt;
    start_in        = 1'b1;
    signed_in       = s;
    multiplicand_in = a;
    multiplier_in   = b;
    tick();
    start_in = 1'b0;
    wait_done(cyc, busy_cnt);
    check_value({tag, "_done"},    32'(done_out),    32'd1);
    check_value({tag, "_latency"}, 32'(cyc),         32'd4);
    check_value({tag, "_busy"},    32'(busy_cnt),    32'd4);
    check_value({tag, "_product"}, 32'(product_out), 32'(expected));
    check_value({tag, "_cnt_n"},   32'(counter_out), 32'd4);
    tick();
    check_value({tag, "_pulse"},   32'(done_out),    32'd0);
  endtask

  initial begin
    int cyc;
    int busy_cnt;
    int extra_done;

    rst_in          = 1'b1;
    start_in        = 1'b0;
    signed_in       = 1'b0;
    multiplicand_in = '0;
    multiplier_in   = '0;
    tick();
    tick();
    check_value("rst_busy",    32'(busy_out),    32'd0);
    check_value("rst_done",    32'(done_out),    32'd0);
    check_value("rst_product", 32'(product_out), 32'd0);
    check_value("rst_counter", 32'(counter_out), 32'd0);
    rst_in = 1'b0;
    tick();

    // Basic unsigned, signed and extreme operand cases.
    do_mult(1'b0, 6'd31, 6'd24, 12'h2E8, "u31x24");
    check_value("idle_counter", 32'(counter_out), 32'd0);
    check_value("idle_busy",    32'(busy_out),    32'd0);
    do_mult(1'b1, 6'd44, 6'd33, 12'h26C, "s_m20xm31");
    do_mult(1'b1, 6'd41, 6'd47, 12'h187, "s_m23xm17");
    do_mult(1'b1, 6'd31, 6'd32, 12'hC20, "s_31xm32");
    do_mult(1'b1, 6'd32, 6'd32, 12'h400, "s_m32xm32");
    do_mult(1'b0, 6'd63, 6'd63, 12'hF81, "u63x63");
    do_mult(1'b0, 6'd0,  6'd45, 12'h000, "u0x45");
    do_mult(1'b0, 6'd32, 6'd32, 12'h400, "u32x32");

    // Back-to-back: start held high through DONE with the second pair.
    start_in        = 1'b1;
    signed_in       = 1'b0;
    multiplicand_in = 6'd31;
    multiplier_in   = 6'd24;
    tick();
    signed_in       = 1'b1;
    multiplicand_in = 6'd7;
    multiplier_in   = 6'd59;
    wait_done(cyc, busy_cnt);
    check_value("b2b_first_done",    32'(done_out),    32'd1);
    check_value("b2b_first_product", 32'(product_out), 32'h2E8);
    tick();
    start_in = 1'b0;
    check_value("b2b_no_gap_busy",   32'(busy_out),    32'd1);
    check_value("b2b_no_gap_done",   32'(done_out),    32'd0);
    check_value("b2b_held_product",  32'(product_out), 32'h2E8);
    wait_done(cyc, busy_cnt);
    check_value("b2b_second_latency", 32'(cyc),         32'd4);
    check_value("b2b_second_product", 32'(product_out), 32'hFDD);
    tick();

    // Start during RUN must be ignored.
    start_in        = 1'b1;
    signed_in       = 1'b1;
    multiplicand_in = 6'd31;
    multiplier_in   = 6'd32;
    tick();
    start_in = 1'b0;
    wait_counter(4'd2, "ign_reach_cnt2");
    start_in        = 1'b1;
    signed_in       = 1'b0;
    multiplicand_in = 6'd5;
    multiplier_in   = 6'd6;
    tick();
    start_in = 1'b0;
    wait_done(cyc, busy_cnt);
    check_value("ign_product", 32'(product_out), 32'hC20);
    extra_done = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done_out) extra_done++;
    end
    check_value("ign_extra_done", 32'(extra_done), 32'd0);

    // Reset in the middle of an operation.
    start_in        = 1'b1;
    signed_in       = 1'b1;
    multiplicand_in = 6'd41;
    multiplier_in   = 6'd47;
    tick();
    start_in = 1'b0;
    wait_counter(4'd2, "rst_reach_cnt2");
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    check_value("midrst_busy",    32'(busy_out),    32'd0);
    check_value("midrst_product", 32'(product_out), 32'd0);
    check_value("midrst_counter", 32'(counter_out), 32'd0);
    check_value("midrst_done",    32'(done_out),    32'd0);
    extra_done = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done_out) extra_done++;
    end
    check_value("midrst_no_done", 32'(extra_done), 32'd0);
    do_mult(1'b0, 6'd5, 6'd6, 12'd30, "u5x6");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
